// File: rtl/audio_fifo_pkg.sv
// Shared types and helpers for the multi-channel audio sample FIFO.
// frame_t and chan() describe the default 2 x 16-bit stereo frame layout.
package audio_fifo_pkg;

    localparam int AUDIO_WIDTH    = 16;
    localparam int AUDIO_CHANNELS = 2;
    localparam int UNDERRUN_CNT_W = 8;

    typedef logic [AUDIO_CHANNELS*AUDIO_WIDTH-1:0] frame_t;

    // Channel 0 sits in the least significant bits of a frame.
    function automatic logic signed [AUDIO_WIDTH-1:0] chan(input frame_t frame, input int idx);
        return frame[idx*AUDIO_WIDTH +: AUDIO_WIDTH];
    endfunction

endpackage

// File: rtl/audio_fifo_ram.sv
// Single-clock 1W/1R frame store with registered read data.
// A read and write to the same address in one cycle returns the old contents.
module audio_fifo_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/audio_fifo_mc.sv
// Multi-channel audio frame FIFO between the CD/XA decoders and the mixer.
// Adds headroom back-pressure, level reporting, flush and underrun handling.
module audio_fifo_mc
    import audio_fifo_pkg::*;
#(
    parameter int WIDTH          = AUDIO_WIDTH,
    parameter int CHANNELS       = AUDIO_CHANNELS,
    parameter int DEPTH_LOG2     = 6,
    parameter int HEADROOM       = 4,
    parameter int NEARLY_FULL_TH = 48,
    parameter int HOLD_LAST      = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_write,
    output logic                        in_strobe,
    input  logic [CHANNELS*WIDTH-1:0]   in_frame,
    output logic                        out_write,
    input  logic                        out_strobe,
    output logic [CHANNELS*WIDTH-1:0]   out_frame,
    output logic [DEPTH_LOG2:0]         level,
    output logic                        nearly_full,
    output logic                        underrun,
    output logic [UNDERRUN_CNT_W-1:0]   underrun_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int LIMIT = DEPTH - HEADROOM;
    localparam int FW    = CHANNELS * WIDTH;

    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_next;
    logic [CNT_W-1:0]      count;
    logic                  hazard_q;
    logic [FW-1:0]         ram_q, last_q;
    logic                  hold, take;

    assign hold        = reset || flush;
    assign in_strobe   = in_write && (count < CNT_W'(LIMIT)) && !hold;
    assign out_write   = (count != '0) && !hold && !hazard_q;
    assign take        = out_strobe && out_write;
    assign underrun    = out_strobe && !out_write && !hold;
    assign level       = count;
    assign nearly_full = count >= CNT_W'(NEARLY_FULL_TH);

    // The RAM is addressed with the pointer that will be current next cycle,
    // so back-to-back takes see fresh data without a bubble.
    always_comb begin
        rd_next = rd_ptr;
        if (hold)      rd_next = '0;
        else if (take) rd_next = rd_ptr + 1'b1;
    end

    assign out_frame = out_write ? ram_q : ((HOLD_LAST != 0) ? last_q : '0);

    audio_fifo_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (FW)
    ) u_ram (
        .clk   (clk),
        .we    (in_strobe),
        .waddr (wr_ptr),
        .wdata (in_frame),
        .raddr (rd_next),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            hazard_q     <= 1'b0;
            last_q       <= '0;
            underrun_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            hazard_q <= 1'b0;
        end else begin
            if (in_strobe) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_next;
            if (in_strobe && !take)      count <= count + 1'b1;
            else if (!in_strobe && take) count <= count - 1'b1;
            // Writing the slot the RAM is reading this cycle returns stale data.
            hazard_q <= in_strobe && (wr_ptr == rd_next);
            if (out_write) last_q <= ram_q;
            if (underrun && (underrun_cnt != '1)) underrun_cnt <= underrun_cnt + 1'b1;
        end
    end

    a_count_bound: assert property (@(posedge clk) count <= CNT_W'(LIMIT));
    a_no_store:    assert property (@(posedge clk)
                       (!in_strobe && !reset && !flush) |=> (wr_ptr == $past(wr_ptr)));
    a_level:       assert property (@(posedge clk) level == count);

endmodule

// File: doc/audio_fifo_mc.md
Name: audio_fifo_mc

Overview:
- Parametrised multi-channel audio sample FIFO between the CD-audio/XA decoders and the audio mixer/DAC path.
- Stores one frame per entry: CHANNELS samples of WIDTH bits each, all written or read together.
- Adds the following:
  - configurable depth, headroom and nearly-full threshold;
  - level reporting;
  - synchronous flush;
  - defined underrun handling (hold last frame or mute) with a saturating underrun counter.

Parameters:
- WIDTH, 16: signed sample width per channel.
- CHANNELS, 2: samples per frame (1..4).
- DEPTH_LOG2, 6: FIFO depth is 2**DEPTH_LOG2 frames.
- HEADROOM, 4: in_strobe deasserts when count >= DEPTH-HEADROOM.
- NEARLY_FULL_TH, 48: nearly_full asserts when count >= this value.
- HOLD_LAST, 1: on underrun, 1 = out_frame holds the last delivered frame; 0 = out_frame is zeroed (mute).

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- flush, in, 1: synchronous clear of FIFO contents. Does not clear the underrun counter.
- in_write, in, 1: producer has a frame.
- in_strobe, out, 1: frame accepted this cycle.
- in_frame, in, CHANNELS*WIDTH: channel 0 in the LSBs.
- out_write, out, 1: out_frame holds a valid FIFO frame.
- out_strobe, in, 1: consumer takes the frame this cycle.
- out_frame, out, CHANNELS*WIDTH: registered output.
- level, out, DEPTH_LOG2+1: current count.
- nearly_full, out, 1: count >= NEARLY_FULL_TH.
- underrun, out, 1: single-cycle pulse.
- underrun_cnt, out, 8: saturating at 255. Cleared only by reset.

Behaviour:
- Reset values:
  - all pointers, count, out_write, out_frame and underrun_cnt are 0;
  - in_strobe is 0 while reset or flush is high.
- Acceptance:
  - in_strobe = in_write && count < DEPTH-HEADROOM && !reset && !flush.
  - A frame is stored when in_strobe is 1.
  - The write pointer wraps modulo DEPTH.
- Count:
  - +1 on accept-only, -1 on take-only.
  - Unchanged on simultaneous accept and take.
  - count never exceeds DEPTH-HEADROOM.
- Read side:
  - Memory read is synchronous, with a read address lookahead: next read pointer = rd+1 when a frame is taken.
  - out_write = count != 0 && !reset && !flush && !hazard_q.
  - hazard_q is registered. It is set when a write hits the same address the lookahead reads in the same cycle, which blocks stale read-before-write data for one cycle.
- Latency:
  - On an empty FIFO, a frame accepted in cycle N gives out_write=1 with that frame in cycle N+2.
  - Back-to-back takes sustain 1 frame/cycle when count >= 2.
- Underrun:
  - out_strobe while out_write==0 pulses underrun for one cycle.
  - underrun_cnt increments and saturates at 255.
  - Read pointer and count are unchanged.
  - While out_write==0, out_frame = last delivered frame (HOLD_LAST=1) or all zeros (HOLD_LAST=0).
- Flush:
  - In the next cycle, pointers = 0, count = 0, out_write = 0.
  - A simultaneous write or take is ignored.
  - Memory contents are not cleared.
  - Flush held for several cycles keeps the FIFO empty.
- Reset mid-stream: same as flush, and additionally clears underrun_cnt and zeroes out_frame.
- Wrap-around: pointers are DEPTH_LOG2 bits. Correct operation across 3+ full wraps is required.
- Assertions:
  - count <= DEPTH-HEADROOM;
  - no store when in_strobe=0;
  - level == count.

Decomposition:
- Package audio_fifo_pkg:
  - frame_t as a function of WIDTH/CHANNELS;
  - helper function chan(frame, idx);
  - UNDERRUN_CNT_W = 8.
- Sub-module audio_fifo_ram: single-clock, 1W/1R, synchronous-read RAM of DEPTH x CHANNELS*WIDTH.
- Pointer/count/hazard/underrun logic lives in the top module.

Test Plan:
- Single frame: write 0x1234_ABCD into an empty FIFO at cycle 10 -> out_write=1 at cycle 12 with out_frame=0x1234_ABCD; level reads 1.
- Fill with no reads, using 64 frames offered with values 0..63 -> in_strobe drops after 60 accepts. nearly_full rises when level reaches 48. Draining yields 0..59 in order.
- Simultaneous take and write at level=1 -> level stays 1; data order is preserved across 200 frames of continuous streaming, including 3 pointer wraps.
- Underrun with HOLD_LAST=1: drain to empty after last frame 0x7FFF_8000, then strobe 3 times -> three underrun pulses, underrun_cnt=3, out_frame stays 0x7FFF_8000. With HOLD_LAST=0 -> out_frame=0.
- Flush at level=20 with a write in the same cycle -> next cycle level=0 and out_write=0; underrun_cnt is unchanged. A subsequent write of 0x0001_0002 emerges 2 cycles later.
- Reset mid-stream at level=30, after 300 underruns -> next cycle all outputs are 0. Before reset, underrun_cnt had saturated at 255.
